// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the ROM image loader.
package loader_pkg;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage : loader_pkg

// File: rtl/ram_sp_4kx8.sv
// Program memory: one synchronous write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
// Only the read register is reset; the array contents survive reset.
module ram_sp_4kx8 #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [0:(1 << AW)-1];
   logic [DW-1:0] rdata_q;

   // Write port: store the byte on an accepted transfer.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port: registered lookup, sees pre-write contents on collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule : ram_sp_4kx8

// File: rtl/rom_image_loader.sv
// ROM image loader: streams bytes over valid/ready into the 4K x 8 program
// memory starting at a programmable base, with auto-incrementing address.
// Optional running byte checksum output enabled by LOADER_CHECKSUM_EN.
module rom_image_loader
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              din_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] wr_ptr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
`ifdef LOADER_CHECKSUM_EN
  ,output logic [DATA_W-1:0] csum
`endif
);

   state_e            state_q,     state_d;
   logic [ADDR_W:0]   remain_q,    remain_d;
   logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
   logic              din_ready_q, din_ready_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              xfer_s;

   // din_ready_q is high exactly while in LOAD, so it doubles as the gate.
   assign xfer_s = din_valid & din_ready_q;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      wr_ptr_d = wr_ptr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != {(ADDR_W+1){1'b0}}) begin
                  wr_ptr_d = base;
                  remain_d = len;
                  state_d  = LOAD;
               end else begin
                  state_d  = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (xfer_s) begin
               wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               remain_d = remain_q - {{ADDR_W{1'b0}}, 1'b1};
               if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      din_ready_d = (state_d == LOAD);
      busy_d      = (state_d == LOAD);
      done_d      = (state_d == DONE);
   end

   // State, counters and handshake outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         remain_q    <= '0;
         wr_ptr_q    <= '0;
         din_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remain_q    <= remain_d;
         wr_ptr_q    <= wr_ptr_d;
         din_ready_q <= din_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign din_ready = din_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wr_ptr    = wr_ptr_q;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   // Running modulo-256 sum: cleared on an accepted start, summed per transfer.
   always_comb begin
      csum_d = csum_q;
      if (state_q == IDLE && start) begin
         csum_d = '0;
      end else if (xfer_s) begin
         csum_d = csum_q + din;
      end else begin
         csum_d = csum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign csum = csum_q;
`endif

   ram_sp_4kx8 #(
      .AW(ADDR_W),
      .DW(DATA_W)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (xfer_s),
      .waddr(wr_ptr_q),
      .wdata(din),
      .raddr(rd_addr),
      .rdata(rd_data)
   );

endmodule : rom_image_loader

// File: tb/tb_rom_image_loader.sv
// Self-checking bench for rom_image_loader: directed loads plus a
// spec-level model checked every cycle. Define LOADER_CHECKSUM_EN to
// also exercise the checksum output.
module tb_rom_image_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base = 12'h000;
   logic [12:0] len = 13'h0000;
   logic        din_valid = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        din_ready;
   logic        busy;
   logic        done;
   logic [11:0] wr_ptr;
   logic [11:0] rd_addr = 12'h000;
   logic [7:0]  rd_data;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   bit chk_en   = 1'b0;

   rom_image_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
      .din_valid(din_valid),
      .din      (din),
      .din_ready(din_ready),
      .busy     (busy),
      .done     (done),
      .wr_ptr   (wr_ptr),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
`ifdef LOADER_CHECKSUM_EN
     ,.csum     (csum)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 waiting for a start, 1 accepting bytes, 2 reporting completion
   int         m_phase = 0;
   int         m_left  = 0;
   int         m_next  = 0;
   logic [7:0] m_sum   = 8'h00;
   logic [7:0] m_mem   [4096];
   bit         m_known [4096];
   logic [7:0] m_rd    = 8'h00;
   bit         m_rd_ok = 1'b0;

   always @(posedge clk) begin
      m_rd    <= m_mem[rd_addr];
      m_rd_ok <= m_known[rd_addr];
      if (!reset) begin
         m_phase <= 0;
         m_left  <= 0;
         m_next  <= 0;
         m_sum   <= 8'h00;
         m_rd    <= 8'h00;
         m_rd_ok <= 1'b1;
      end else if (m_phase == 0) begin
         if (start) begin
            m_sum <= 8'h00;
            if (len != 13'd0) begin
               m_next  <= int'(base);
               m_left  <= int'(len);
               m_phase <= 1;
            end else begin
               m_phase <= 2;
            end
         end
      end else if (m_phase == 1) begin
         if (din_valid) begin
            m_mem[m_next]   <= din;
            m_known[m_next] <= 1'b1;
            m_next          <= (m_next + 1) % 4096;
            m_left          <= m_left - 1;
            m_sum           <= m_sum + din;
            if (m_left == 1) m_phase <= 2;
         end
      end else begin
         m_phase <= 0;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("din_ready", {31'd0, din_ready}, {31'd0, m_phase == 1});
         check("busy",      {31'd0, busy},      {31'd0, m_phase == 1});
         check("done",      {31'd0, done},      {31'd0, m_phase == 2});
         check("wr_ptr",    {20'd0, wr_ptr},    m_next);
         if (m_rd_ok) check("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
`ifdef LOADER_CHECKSUM_EN
         if (m_phase == 2) check("csum", {24'd0, csum}, {24'd0, m_sum});
`endif
      end
   end

   // Done pulse counter.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic rd_check(input string name, input logic [11:0] a, input logic [7:0] exp);
      rd_addr = a;
      cyc();
      check(name, {24'd0, rd_data}, {24'd0, exp});
   endtask

   int d0;

   initial begin
      // reset
      reset = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      check("rst_ready", {31'd0, din_ready}, 32'd0);
      check("rst_wrptr", {20'd0, wr_ptr}, 32'd0);
      check("rst_rddata", {24'd0, rd_data}, 32'd0);
      reset = 1'b1;
      cyc();

      // basic load at 0x010
      d0 = done_cnt;
      start = 1'b1; base = 12'h010; len = 13'd4;
      cyc();
      start = 1'b0; din_valid = 1'b1; din = 8'hA1;
      cyc(); din = 8'hB2;
      cyc(); din = 8'hC3;
      cyc(); din = 8'hD4;
      cyc(); din_valid = 1'b0;
      check("basic_done", {31'd0, done}, 32'd1);
      check("basic_wrptr", {20'd0, wr_ptr}, 32'h014);
      cyc();
      check("basic_done_clr", {31'd0, done}, 32'd0);
      cyc();
      check("basic_done_cnt", done_cnt - d0, 32'd1);
      rd_check("rd_010", 12'h010, 8'hA1);
      rd_check("rd_011", 12'h011, 8'hB2);
      rd_check("rd_012", 12'h012, 8'hC3);
      rd_check("rd_013", 12'h013, 8'hD4);

      // address wrap
      start = 1'b1; base = 12'hFFE; len = 13'd4;
      cyc();
      start = 1'b0; din_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         din = 8'(i);
         cyc();
      end
      din_valid = 1'b0;
      check("wrap_wrptr", {20'd0, wr_ptr}, 32'h002);
      cyc();
      rd_check("rd_ffe", 12'hFFE, 8'h01);
      rd_check("rd_fff", 12'hFFF, 8'h02);
      rd_check("rd_000", 12'h000, 8'h03);
      rd_check("rd_001", 12'h001, 8'h04);

      // backpressure gaps: valid 1,0,0,1,0,1
      d0 = done_cnt;
      start = 1'b1; base = 12'h100; len = 13'd3;
      cyc();
      start = 1'b0;
      din_valid = 1'b1; din = 8'h55; cyc();
      din_valid = 1'b0; din = 8'hEE; cyc();
      check("bp_busy1", {31'd0, busy}, 32'd1);
      cyc();
      din_valid = 1'b1; din = 8'h66; cyc();
      din_valid = 1'b0; din = 8'hEE; cyc();
      check("bp_busy2", {31'd0, busy}, 32'd1);
      din_valid = 1'b1; din = 8'h77; cyc();
      din_valid = 1'b0;
      check("bp_done", {31'd0, done}, 32'd1);
      cyc(); cyc();
      check("bp_done_cnt", done_cnt - d0, 32'd1);
      check("bp_wrptr", {20'd0, wr_ptr}, 32'h103);
      rd_check("rd_100", 12'h100, 8'h55);
      rd_check("rd_101", 12'h101, 8'h66);
      rd_check("rd_102", 12'h102, 8'h77);

      // len = 0: done next cycle, nothing written
      start = 1'b1; base = 12'h010; len = 13'd0; din_valid = 1'b1; din = 8'h99;
      cyc();
      start = 1'b0; din_valid = 1'b0;
      check("len0_done", {31'd0, done}, 32'd1);
      check("len0_wrptr", {20'd0, wr_ptr}, 32'h103);
      cyc();
      rd_check("len0_rd_010", 12'h010, 8'hA1);

      // start during LOAD and during DONE is ignored
      start = 1'b1; base = 12'h200; len = 13'd2;
      cyc();
      base = 12'h300; len = 13'd5; din_valid = 1'b1; din = 8'h11;
      cyc();
      start = 1'b0; din = 8'h22;
      cyc();
      din_valid = 1'b0;
      check("ign_done", {31'd0, done}, 32'd1);
      check("ign_wrptr", {20'd0, wr_ptr}, 32'h202);
      start = 1'b1; base = 12'h400; len = 13'd1;
      cyc();
      start = 1'b0;
      check("ign_done_busy", {31'd0, busy}, 32'd0);
      check("ign_done_wrptr", {20'd0, wr_ptr}, 32'h202);
      rd_check("rd_200", 12'h200, 8'h11);
      rd_check("rd_201", 12'h201, 8'h22);

      // reset mid-load after 3 transfers
      d0 = done_cnt;
      start = 1'b1; base = 12'h500; len = 13'd8;
      cyc();
      start = 1'b0; din_valid = 1'b1;
      din = 8'h31; cyc();
      din = 8'h32; cyc();
      din = 8'h33; cyc();
      din_valid = 1'b0; reset = 1'b0;
      cyc();
      check("mid_rst_ready", {31'd0, din_ready}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_wrptr", {20'd0, wr_ptr}, 32'd0);
      reset = 1'b1;
      cyc(); cyc();
      check("mid_rst_no_done", done_cnt - d0, 32'd0);
      rd_check("rd_500", 12'h500, 8'h31);
      rd_check("rd_501", 12'h501, 8'h32);
      rd_check("rd_502", 12'h502, 8'h33);

`ifdef LOADER_CHECKSUM_EN
      start = 1'b1; base = 12'h600; len = 13'd3;
      cyc();
      start = 1'b0; din_valid = 1'b1;
      din = 8'hFF; cyc();
      din = 8'h02; cyc();
      din = 8'h10; cyc();
      din_valid = 1'b0;
      check("csum_done", {31'd0, done}, 32'd1);
      check("csum_val", {24'd0, csum}, 32'h11);
      cyc();
      check("csum_hold", {24'd0, csum}, 32'h11);
`endif

      cyc(); cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rom_image_loader
